// File: rtl/sid_pkg.sv
// Shared SID definitions: register map constants, mixer FSM states and
// the 18-to-16 bit saturation helper used on the audio path.
package sid_pkg;

    localparam logic [4:0] SID_REG_MODEVOL = 5'h18;

    // Bit positions of the filter mode selects inside the $18 data byte
    localparam int MODE_LP = 4;
    localparam int MODE_BP = 5;
    localparam int MODE_HP = 6;

    typedef enum logic [2:0] {
        MIX_IDLE,
        MIX_SUM,
        MIX_SAT,
        MIX_MUL,
        MIX_DONE
    } mix_state_t;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] x);
        logic signed [15:0] r;
        if (x > 18'sd32767)
            r = 16'sh7fff;
        else if (x < -18'sd32768)
            r = 16'sh8000;
        else
            r = x[15:0];
        return r;
    endfunction

endpackage

// File: rtl/seq_mul16x4.sv
// Four-cycle shift-add multiplier: signed 16-bit sample times unsigned
// 4-bit volume, one volume bit per cycle, LSB first.
module seq_mul16x4 (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               start,
    input  logic signed [15:0] a,
    input  logic        [3:0]  b,
    output logic               busy,
    output logic               done,
    output logic signed [19:0] product
);

    logic signed [15:0] a_q;
    logic        [3:0]  b_q;
    logic signed [19:0] acc;
    logic        [1:0]  cnt;
    logic signed [19:0] a_ext;
    logic signed [19:0] addend;

    assign a_ext   = {{4{a_q[15]}}, a_q};
    assign addend  = a_ext <<< cnt;
    // High during the final accumulate cycle; product is complete after it
    assign done    = busy && (cnt == 2'd3);
    assign product = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (clear) begin
            busy <= 1'b0;
        end else if (start) begin
            a_q  <= a;
            b_q  <= b;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (b_q[cnt])
                acc <= acc + addend;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/filter_mixer.sv
// SID output mixer: captures filter/bypass samples on the sample strobe,
// sums the selected modes, saturates and applies master volume.
module filter_mixer
    import sid_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clkEn,
    input  logic signed [15:0] iLP,
    input  logic signed [15:0] iBP,
    input  logic signed [15:0] iHP,
    input  logic signed [15:0] iBypass,
    input  logic               WR,
    input  logic        [4:0]  ADDR,
    input  logic        [7:0]  DATA,
    output logic signed [15:0] oOut,
    output logic               oValid
);

    mix_state_t state, state_next;

    logic        [2:0]  reg_mode;
    logic        [3:0]  reg_vol;
    logic signed [15:0] s_lp, s_bp, s_hp, s_byp;
    logic        [2:0]  s_mode;
    logic        [3:0]  s_vol;
    logic signed [17:0] sum_q, sum_next;
    logic signed [17:0] lp_x, bp_x, hp_x, byp_x;
    logic               mul_start, mul_busy, mul_done;
    logic signed [19:0] mul_product;

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_mode <= '0;
            reg_vol  <= '0;
        end else if (WR && ADDR == SID_REG_MODEVOL) begin
            reg_mode <= DATA[MODE_HP:MODE_LP];
            reg_vol  <= DATA[3:0];
        end
    end

    // Capture sees the pre-write register values when WR and clkEn coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            s_lp   <= '0;
            s_bp   <= '0;
            s_hp   <= '0;
            s_byp  <= '0;
            s_mode <= '0;
            s_vol  <= '0;
        end else if (clkEn) begin
            s_lp   <= iLP;
            s_bp   <= iBP;
            s_hp   <= iHP;
            s_byp  <= iBypass;
            s_mode <= reg_mode;
            s_vol  <= reg_vol;
        end
    end

    assign lp_x  = {{2{s_lp[15]}},  s_lp};
    assign bp_x  = {{2{s_bp[15]}},  s_bp};
    assign hp_x  = {{2{s_hp[15]}},  s_hp};
    assign byp_x = {{2{s_byp[15]}}, s_byp};

    always_comb begin
        sum_next = byp_x;
        if (s_mode[MODE_LP - MODE_LP]) sum_next = sum_next + lp_x;
        if (s_mode[MODE_BP - MODE_LP]) sum_next = sum_next + bp_x;
        if (s_mode[MODE_HP - MODE_LP]) sum_next = sum_next + hp_x;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sum_q <= '0;
        else if (state == MIX_SUM)
            sum_q <= sum_next;
    end

    // Saturation happens in the SAT cycle as the multiplier loads its operand
    assign mul_start = (state == MIX_SAT);

    seq_mul16x4 u_mul (
        .clk     (clk),
        .rst     (rst),
        .clear   (clkEn),
        .start   (mul_start),
        .a       (sat16(sum_q)),
        .b       (s_vol),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= MIX_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clkEn) begin
            state_next = MIX_SUM;
        end else begin
            case (state)
                MIX_IDLE: state_next = MIX_IDLE;
                MIX_SUM:  state_next = MIX_SAT;
                MIX_SAT:  state_next = MIX_MUL;
                MIX_MUL:  if (mul_done) state_next = MIX_DONE;
                MIX_DONE: state_next = MIX_IDLE;
                default:  state_next = MIX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oOut   <= '0;
            oValid <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (state == MIX_DONE && !clkEn) begin
                oOut   <= mul_product[19:4];
                oValid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_filter_mixer.sv
// Scoreboarded bench for filter_mixer: each strobe pushes the expected
// sample and its arrival cycle; the monitor pops them on oValid.
module tb_filter_mixer;

    logic               clk = 1'b0;
    logic               rst;
    logic               clkEn;
    logic signed [15:0] iLP, iBP, iHP, iBypass;
    logic               WR;
    logic        [4:0]  ADDR;
    logic        [7:0]  DATA;
    logic signed [15:0] oOut;
    logic               oValid;

    filter_mixer dut (
        .clk     (clk),
        .rst     (rst),
        .clkEn   (clkEn),
        .iLP     (iLP),
        .iBP     (iBP),
        .iHP     (iHP),
        .iBypass (iBypass),
        .WR      (WR),
        .ADDR    (ADDR),
        .DATA    (DATA),
        .oOut    (oOut),
        .oValid  (oValid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [2:0]  sh_mode;
    logic [3:0]  sh_vol;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input logic signed [15:0] lp, input logic signed [15:0] bp,
                                 input logic signed [15:0] hp, input logic signed [15:0] byp,
                                 input logic [2:0] mode, input logic [3:0] vol);
        int s;
        s = int'(byp);
        if (mode[0]) s += int'(lp);
        if (mode[1]) s += int'(bp);
        if (mode[2]) s += int'(hp);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return (s * int'(vol)) >>> 4;
    endfunction

    always @(negedge clk) begin
        if (oValid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                logic [15:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("sample", int'(oOut), int'($signed(e)));
                check("latency", cyc, ec);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_strobe(input logic signed [15:0] lp, input logic signed [15:0] bp,
                                input logic signed [15:0] hp, input logic signed [15:0] byp);
        iLP = lp; iBP = bp; iHP = hp; iBypass = byp;
        clkEn = 1'b1;
        // A strobe abandons whatever sample is still in flight
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            void'(exp_cyc_q.pop_back());
        end
        exp_q.push_back(16'(model(lp, bp, hp, byp, sh_mode, sh_vol)));
        exp_cyc_q.push_back(cyc + 8);
    endtask

    task automatic strobe(input logic signed [15:0] lp, input logic signed [15:0] bp,
                          input logic signed [15:0] hp, input logic signed [15:0] byp);
        drive_strobe(lp, bp, hp, byp);
        @(negedge clk);
        clkEn = 1'b0;
    endtask

    task automatic strobe_wr(input logic signed [15:0] lp, input logic signed [15:0] bp,
                             input logic signed [15:0] hp, input logic signed [15:0] byp,
                             input logic [7:0] data);
        drive_strobe(lp, bp, hp, byp);
        WR = 1'b1; ADDR = 5'h18; DATA = data;
        sh_mode = data[6:4];
        sh_vol  = data[3:0];
        @(negedge clk);
        clkEn = 1'b0;
        WR    = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [7:0] data);
        WR = 1'b1; ADDR = addr; DATA = data;
        if (addr == 5'h18 && !rst) begin
            sh_mode = data[6:4];
            sh_vol  = data[3:0];
        end
        @(negedge clk);
        WR = 1'b0;
    endtask

    initial begin
        int waited;
        logic [3:0] vols[4];
        rst = 1'b1; clkEn = 1'b0; WR = 1'b0; ADDR = '0; DATA = '0;
        iLP = '0; iBP = '0; iHP = '0; iBypass = '0;
        sh_mode = '0; sh_vol = '0;
        idle(3);
        check("reset_out", int'(oOut), 0);
        check("reset_valid", int'(oValid), 0);
        rst = 1'b0;
        idle(2);

        // Reset in the middle of the multiply, with writes and a strobe during reset
        write_reg(5'h18, 8'h7f);
        strobe(16'sd0, 16'sd0, 16'sd0, 16'sd1000);
        idle(3);
        rst = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        sh_mode = '0; sh_vol = '0;
        write_reg(5'h18, 8'h7f);
        iBypass = 16'sd1000; clkEn = 1'b1;
        idle(1);
        clkEn = 1'b0;
        idle(1);
        check("rst_hold_out", int'(oOut), 0);
        check("rst_hold_valid", int'(oValid), 0);
        rst = 1'b0;
        idle(10);
        strobe(16'sd0, 16'sd0, 16'sd0, 16'sd1000);
        idle(10);

        // Mode selection
        write_reg(5'h18, 8'h1f);
        strobe(16'sd1000, 16'sd2000, 16'sd3000, 16'sd500);
        idle(10);
        write_reg(5'h18, 8'h7f);
        strobe(16'sd1000, 16'sd2000, 16'sd3000, 16'sd500);
        idle(10);
        write_reg(5'h18, 8'h3f);
        strobe(16'sd1000, 16'sd2000, 16'sd3000, 16'sd500);
        idle(10);
        write_reg(5'h18, 8'hcf);
        strobe(16'sd1000, 16'sd2000, 16'sd3000, 16'sd500);
        idle(10);

        // Saturation and rounding toward -inf
        write_reg(5'h18, 8'h7f);
        strobe(16'sd30000, 16'sd30000, 16'sd30000, 16'sd30000);
        idle(10);
        strobe(-16'sd30000, -16'sd30000, -16'sd30000, -16'sd30000);
        idle(10);
        write_reg(5'h18, 8'h01);
        strobe(16'sd0, 16'sd0, 16'sd0, -16'sd1);
        idle(10);
        write_reg(5'h18, 8'h11);
        strobe(-16'sd1, 16'sd5, 16'sd5, 16'sd0);
        idle(10);

        // Volume sweep; write to an unrelated address must not disturb volume
        vols = '{4'd0, 4'd1, 4'd8, 4'd15};
        foreach (vols[i]) begin
            write_reg(5'h18, {4'h0, vols[i]});
            write_reg(5'h17, 8'h05);
            strobe(16'sd0, 16'sd0, 16'sd0, 16'sd16000);
            idle(10);
        end

        // Second strobe four cycles after the first aborts the first
        write_reg(5'h18, 8'h7f);
        strobe(16'sd100, 16'sd200, 16'sd300, 16'sd400);
        idle(3);
        strobe(16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000);
        idle(10);

        // Write coincident with strobe: old volume applies, new one afterwards
        strobe_wr(16'sd0, 16'sd0, 16'sd0, 16'sd16000, 8'h01);
        idle(10);
        strobe(16'sd0, 16'sd0, 16'sd0, 16'sd16000);
        idle(10);

        for (int k = 0; k < 8; k++) begin
            logic [15:0] r0, r1, r2, r3;
            r0 = 16'($urandom_range(0, 65535));
            r1 = 16'($urandom_range(0, 65535));
            r2 = 16'($urandom_range(0, 65535));
            r3 = 16'($urandom_range(0, 65535));
            write_reg(5'h18, 8'($urandom_range(0, 255)));
            strobe($signed(r0), $signed(r1), $signed(r2), $signed(r3));
            idle(9);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 50) begin
            idle(1);
            waited++;
        end
        check("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
